// File: rtl/seg7_scan_driver.sv
// Four-digit seven-segment driver: latches a 16-bit value, optionally converts it
// to BCD by sequential double-dabble, and scans it onto active-low SEG/AN/DP pins.
module seg7_scan_driver #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int REFRESH_HZ  = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] data_in,
  input  logic        data_valid,
  input  logic        dec_mode,
  input  logic        blank_lz,
  input  logic [3:0]  dp_in,
  output logic        busy,
  output logic [6:0]  SEG,
  output logic [3:0]  AN,
  output logic        DP
);

  localparam int TICKS_RAW   = CLK_FREQ_HZ / REFRESH_HZ;
  localparam int DIGIT_TICKS = (TICKS_RAW < 2) ? 2 : TICKS_RAW;
  localparam int TW          = $clog2(DIGIT_TICKS);
  localparam logic [TW-1:0] TICK_LAST = TW'(DIGIT_TICKS - 1);

  localparam logic [6:0] SEG_OFF  = 7'b1111111;
  localparam logic [6:0] SEG_DASH = 7'b0111111;

  // state  | meaning
  // IDLE   | waiting for data_valid
  // CONV   | 16 double-dabble iterations
  // COMMIT | one cycle: write display registers
  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

  state_t        state_q, state_d;
  logic          busy_q, busy_d;
  logic [15:0]   val_q, val_d;
  logic          dec_q, dec_d;
  logic          blz_q, blz_d;
  logic [19:0]   bcd_q, bcd_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [15:0]   digit_q, digit_d;
  logic          ovf_q, ovf_d;
  logic [3:0]    mask_q, mask_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [1:0]    idx_q, idx_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    an_q, an_d;
  logic          dp_q, dp_d;

  logic [19:0]   bcd_adj;
  logic [15:0]   commit_digits;
  logic          commit_ovf;
  logic [3:0]    commit_mask;
  logic [3:0]    cur_digit;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'h0: glyph = 7'b1000000;
      4'h1: glyph = 7'b1111001;
      4'h2: glyph = 7'b0100100;
      4'h3: glyph = 7'b0110000;
      4'h4: glyph = 7'b0011001;
      4'h5: glyph = 7'b0010010;
      4'h6: glyph = 7'b0000010;
      4'h7: glyph = 7'b1111000;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0010000;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b0000011;
      4'hC: glyph = 7'b1000110;
      4'hD: glyph = 7'b0100001;
      4'hE: glyph = 7'b0000110;
      default: glyph = 7'b0001110;
    endcase
  endfunction

  always_comb begin
    bcd_adj = bcd_q;
    for (int n = 0; n < 5; n++) begin
      if (bcd_q[4*n +: 4] >= 4'd5) bcd_adj[4*n +: 4] = bcd_q[4*n +: 4] + 4'd3;
    end
  end

  // Leading-zero mask is suppressed on overflow so the dashes stay visible.
  always_comb begin
    commit_digits  = dec_q ? bcd_q[15:0] : val_q;
    commit_ovf     = dec_q & (bcd_q[19:16] != 4'd0);
    commit_mask    = 4'b0000;
    if (blz_q && !commit_ovf) begin
      commit_mask[3] = (commit_digits[15:12] == 4'd0);
      commit_mask[2] = commit_mask[3] && (commit_digits[11:8] == 4'd0);
      commit_mask[1] = commit_mask[2] && (commit_digits[7:4] == 4'd0);
    end
  end

  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    dec_d   = dec_q;
    blz_d   = blz_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    digit_d = digit_q;
    ovf_d   = ovf_q;
    mask_d  = mask_q;
    case (state_q)
      IDLE: begin
        if (data_valid) begin
          val_d   = data_in;
          dec_d   = dec_mode;
          blz_d   = blank_lz;
          bcd_d   = 20'd0;
          cnt_d   = 4'd0;
          state_d = dec_mode ? CONV : COMMIT;
        end
      end
      CONV: begin
        // val_q doubles as the shift source; hex mode never reaches this state.
        bcd_d = {bcd_adj[18:0], val_q[15]};
        val_d = {val_q[14:0], 1'b0};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) state_d = COMMIT;
      end
      COMMIT: begin
        digit_d = commit_digits;
        ovf_d   = commit_ovf;
        mask_d  = commit_mask;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_comb begin
    tick_d    = (tick_q == TICK_LAST) ? '0 : tick_q + TW'(1);
    idx_d     = (tick_q == TICK_LAST) ? idx_q + 2'd1 : idx_q;
    cur_digit = digit_q[{idx_q, 2'b00} +: 4];
    seg_d     = SEG_OFF;
    an_d      = 4'b1111;
    dp_d      = 1'b1;
    if (!mask_q[idx_q]) begin
      an_d  = ~(4'b0001 << idx_q);
      dp_d  = ~dp_in[idx_q];
      seg_d = ovf_q ? SEG_DASH : glyph(cur_digit);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      val_q   <= '0;
      dec_q   <= 1'b0;
      blz_q   <= 1'b0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      digit_q <= '0;
      ovf_q   <= 1'b0;
      mask_q  <= '0;
      tick_q  <= '0;
      idx_q   <= '0;
      seg_q   <= SEG_OFF;
      an_q    <= 4'b1111;
      dp_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      val_q   <= val_d;
      dec_q   <= dec_d;
      blz_q   <= blz_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      digit_q <= digit_d;
      ovf_q   <= ovf_d;
      mask_q  <= mask_d;
      tick_q  <= tick_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      dp_q    <= dp_d;
    end
  end

  assign busy = busy_q;
  assign SEG  = seg_q;
  assign AN   = an_q;
  assign DP   = dp_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver at DIGIT_TICKS=4: table of loads with
// per-slot expected pins, plus hand sequences for collisions and reset.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] data_in;
  logic        data_valid;
  logic        dec_mode;
  logic        blank_lz;
  logic [3:0]  dp_in;
  logic        busy;
  logic [6:0]  SEG;
  logic [3:0]  AN;
  logic        DP;

  seg7_scan_driver #(.CLK_FREQ_HZ(4000), .REFRESH_HZ(1000)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
    .dec_mode(dec_mode), .blank_lz(blank_lz), .dp_in(dp_in),
    .busy(busy), .SEG(SEG), .AN(AN), .DP(DP)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] G0 = 7'b1000000, G1 = 7'b1111001, G2 = 7'b0100100, G3 = 7'b0110000;
  localparam logic [6:0] G4 = 7'b0011001, G5 = 7'b0010010, G7 = 7'b1111000, G9 = 7'b0010000;
  localparam logic [6:0] GA = 7'b0001000, Gb = 7'b0000011, GC = 7'b1000110, GE = 7'b0000110;
  localparam logic [6:0] GF = 7'b0001110, GDASH = 7'b0111111;
  localparam logic [11:0] BLANK = 12'hFFF;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_cnt = 0;

  // Edges since reset release; output after edge e shows slot ((e-1)/4)%4.
  always @(posedge clk) edge_cnt <= rst ? 0 : edge_cnt + 1;

  typedef struct {
    logic [15:0] data;
    logic        dec;
    logic        blz;
    logic [3:0]  dp;
    int          busy_exp;
    logic [47:0] exp;
  } vec_t;

  vec_t vecs[9];

  function automatic int slot();
    return ((edge_cnt - 1) / 4) % 4;
  endfunction

  function automatic logic [11:0] act(input int s, input logic [6:0] g, input logic dpr);
    logic [3:0] an;
    an    = 4'b1111;
    an[s] = 1'b0;
    return {an, g, ~dpr};
  endfunction

  function automatic logic [47:0] pack4(input logic [11:0] e0, input logic [11:0] e1,
                                        input logic [11:0] e2, input logic [11:0] e3);
    return {e3, e2, e1, e0};
  endfunction

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scan_check(input string name, input logic [47:0] exp);
    int s;
    for (int c = 0; c < 16; c++) begin
      tick();
      s = slot();
      check($sformatf("%s slot%0d {AN,SEG,DP}", name, s), 32'({AN, SEG, DP}), 32'(exp[s*12 +: 12]));
    end
  endtask

  task automatic load_measure(input logic [15:0] d, input logic dc, input logic bz,
                              input logic [47:0] prev, output int bc);
    int s;
    data_in    = d;
    dec_mode   = dc;
    blank_lz   = bz;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    bc = 0;
    while (busy === 1'b1 && bc < 40) begin
      bc++;
      s = slot();
      check("hold old display", 32'({AN, SEG}), 32'(prev[s*12+1 +: 11]));
      tick();
    end
  endtask

  task automatic set_vec(input int i, input logic [15:0] d, input logic dc, input logic bz,
                         input logic [3:0] dp, input int be, input logic [47:0] e);
    vecs[i].data = d; vecs[i].dec = dc; vecs[i].blz = bz;
    vecs[i].dp = dp; vecs[i].busy_exp = be; vecs[i].exp = e;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [47:0] zero_disp;
    logic [47:0] prev;
    logic [47:0] e4321;
    int bc;

    zero_disp = pack4(act(0, G0, 0), act(1, G0, 0), act(2, G0, 0), act(3, G0, 0));
    e4321     = pack4(act(0, G1, 0), act(1, G2, 0), act(2, G3, 0), act(3, G4, 0));

    set_vec(0, 16'hBEEF, 0, 0, 4'b0000, 1,
            pack4(act(0, GF, 0), act(1, GE, 0), act(2, GE, 0), act(3, Gb, 0)));
    set_vec(1, 16'd1234, 1, 0, 4'b0000, 17,
            pack4(act(0, G4, 0), act(1, G3, 0), act(2, G2, 0), act(3, G1, 0)));
    set_vec(2, 16'd10000, 1, 0, 4'b0000, 17,
            pack4(act(0, GDASH, 0), act(1, GDASH, 0), act(2, GDASH, 0), act(3, GDASH, 0)));
    set_vec(3, 16'd65535, 1, 1, 4'b0000, 17,
            pack4(act(0, GDASH, 0), act(1, GDASH, 0), act(2, GDASH, 0), act(3, GDASH, 0)));
    set_vec(4, 16'd9999, 1, 0, 4'b0000, 17,
            pack4(act(0, G9, 0), act(1, G9, 0), act(2, G9, 0), act(3, G9, 0)));
    set_vec(5, 16'h0007, 0, 1, 4'b0001, 1, pack4(act(0, G7, 1), BLANK, BLANK, BLANK));
    set_vec(6, 16'h0000, 0, 1, 4'b0000, 1, pack4(act(0, G0, 0), BLANK, BLANK, BLANK));
    set_vec(7, 16'h0A05, 0, 1, 4'b1010, 1,
            pack4(act(0, G5, 0), act(1, G0, 1), act(2, GA, 0), BLANK));
    set_vec(8, 16'd42, 1, 1, 4'b0000, 17, pack4(act(0, G2, 0), act(1, G4, 0), BLANK, BLANK));

    rst = 1'b1; data_in = '0; data_valid = 1'b0; dec_mode = 1'b0; blank_lz = 1'b0; dp_in = 4'b0000;
    repeat (3) tick();
    check("reset SEG", 32'(SEG), 32'(7'b1111111));
    check("reset AN", 32'(AN), 32'(4'b1111));
    check("reset DP", 32'(DP), 32'(1'b1));
    check("reset busy", 32'(busy), 32'(1'b0));
    rst = 1'b0;
    scan_check("reset scan", zero_disp);
    prev = zero_disp;

    for (int i = 0; i < 9; i++) begin
      dp_in = vecs[i].dp;
      load_measure(vecs[i].data, vecs[i].dec, vecs[i].blz, prev, bc);
      check($sformatf("vec%0d busy cycles", i), 32'(bc), 32'(vecs[i].busy_exp));
      scan_check($sformatf("vec%0d", i), vecs[i].exp);
      prev = vecs[i].exp;
    end
    dp_in = 4'b0000;

    // data_valid during CONV iteration 5 must be ignored
    data_in = 16'd4321; dec_mode = 1'b1; blank_lz = 1'b0; data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    bc = 0;
    while (busy === 1'b1 && bc < 40) begin
      bc++;
      if (bc == 5) begin
        data_in = 16'h1111; dec_mode = 1'b0; data_valid = 1'b1;
      end else begin
        data_valid = 1'b0;
      end
      tick();
    end
    data_valid = 1'b0;
    check("conv collide busy cycles", 32'(bc), 32'd17);
    scan_check("conv collide", e4321);

    // dp_in is live: visible one edge after it changes
    dp_in = 4'b1111;
    tick();
    check("dp live on", 32'(DP), 32'(1'b0));
    dp_in = 4'b0000;
    tick();
    check("dp live off", 32'(DP), 32'(1'b0) ^ 32'd1);

    // data_valid held into COMMIT must be ignored
    data_in = 16'h00C3; dec_mode = 1'b0; blank_lz = 1'b0; data_valid = 1'b1;
    tick();
    check("commit collide busy", 32'(busy), 32'(1'b1));
    data_in = 16'h5555;
    tick();
    data_valid = 1'b0;
    check("commit collide busy drop", 32'(busy), 32'(1'b0));
    scan_check("commit collide", pack4(act(0, G3, 0), act(1, GC, 0), act(2, G0, 0), act(3, G0, 0)));

    // reset in CONV iteration 8 abandons the conversion and clears the display
    data_in = 16'd1234; dec_mode = 1'b1; blank_lz = 1'b0; data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    repeat (7) tick();
    check("pre-reset busy", 32'(busy), 32'(1'b1));
    rst = 1'b1;
    tick();
    check("mid-conv rst busy", 32'(busy), 32'(1'b0));
    check("mid-conv rst SEG", 32'(SEG), 32'(7'b1111111));
    check("mid-conv rst AN", 32'(AN), 32'(4'b1111));
    check("mid-conv rst DP", 32'(DP), 32'(1'b1));
    rst = 1'b0;
    scan_check("after mid-conv rst", zero_disp);
    check("after rst still idle", 32'(busy), 32'(1'b0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Downstream display stage for the Basys 3 four-digit seven-segment display (SEG/AN/DP pins). It accepts a 16-bit value through a load strobe and converts it either to four hex digits or, through sequential double-dabble, to four BCD digits. It then time-multiplexes the digits onto the active-low pins with optional leading-zero blanking and per-digit decimal points. It runs in the 100 MHz system domain and is driven by the CPU GPIO or by debug logic.

## Interface
- CLK_FREQ_HZ, 100_000_000: system clock frequency.
- REFRESH_HZ, 1000: per-digit slot rate. DIGIT_TICKS = CLK_FREQ_HZ/REFRESH_HZ cycles per slot, minimum 2. Benches override this to give DIGIT_TICKS=4.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- data_in  in  16  value to display.
- data_valid  in  1  load strobe; sampled only when busy=0.
- dec_mode  in  1  0 = hex, 1 = unsigned decimal; captured with data_in.
- blank_lz  in  1  1 = suppress leading zeros; captured with data_in.
- dp_in  in  4  decimal-point request per digit (bit i = digit i); sampled live, not latched.
- busy  out  1  conversion in progress; loads ignored.
- SEG  out  7  segments, active low, SEG[0]=a … SEG[6]=g; registered.
- AN  out  4  digit anodes, active low, AN[0] = rightmost digit; registered.
- DP  out  1  decimal point, active low; registered.

## Operation
- FSM states: IDLE, CONV, COMMIT. busy = (state != IDLE), registered.
- **IDLE**, on data_valid=1:
  - Latch data_in, dec_mode and blank_lz.
  - Go to CONV if dec_mode=1, else go to COMMIT.
- **CONV**: 16 iterations of double-dabble, one per cycle, into a 20-bit BCD shift register.
  - Each cycle: add 3 to every BCD nibble ≥5, then shift left by 1, taking the next input MSB.
  - After the 16th iteration, go to COMMIT.
- **COMMIT**: write the display registers for one cycle, then return to IDLE.
  - digit[3:0] ← hex nibbles (hex mode) or BCD[15:0] (decimal mode).
  - ovf ← (BCD[19:16] != 0), i.e. decimal value > 9999. ovf is always 0 in hex mode.
  - blank mask ← leading-zero mask if blank_lz=1, else 0000.
    - Digit i is blanked when digits 3..i are all zero, for i ≥ 1.
    - Digit 0 is never blanked.
    - Blanking is ignored when ovf=1.
- Display registers change only in COMMIT, so a conversion never produces a torn or partial display.
- **Scan:**
  - tick counter runs 0..DIGIT_TICKS-1 and wraps.
  - On wrap, idx advances 0→1→2→3→0.
  - Scanning is independent of the FSM.
- **Output register**, updated every cycle from idx and the display registers:
  - If digit idx is blanked: AN=1111, SEG=1111111, DP=1.
  - Otherwise: AN = ~(1<<idx), DP = ~dp_in[idx].
    - SEG = dash 0111111 if ovf=1.
    - Else SEG = glyph of digit[idx].
- **Glyphs** (gfedcba, active low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110

## Timing
- **Reset:**
  - Values: state=IDLE, busy=0, tick=0, idx=0, digits=0, ovf=0, mask=0000, SEG=1111111, AN=1111, DP=1.
  - First edge after rst falls: AN=1110, SEG=1000000, so the display reads "0000".
- **Hex load** (data_valid at edge k): busy=1 for cycle k+1 only; display registers update at edge k+1; pins reflect the new value from edge k+2.
- **Decimal load:** busy=1 for 17 cycles (16 CONV + 1 COMMIT); pins reflect the new value 18 edges after the load edge.
- data_valid while busy=1: ignored, no queuing.
- Simultaneous COMMIT and data_valid: ignored (busy still 1).
- rst mid-CONV or mid-COMMIT: conversion abandoned; all state returns to reset values; the previous display is cleared to "0000".
- dp_in changes appear on DP one edge after the change, within the active slot.
- Full refresh period = 4·DIGIT_TICKS cycles (4 ms at the defaults).

## Test plan
1. **Reset** (DIGIT_TICKS=4).
   - While rst=1: SEG=1111111, AN=1111, DP=1, busy=0.
   - After release: AN cycles 1110→1101→1011→0111 every 4 cycles; SEG=1000000 in every slot.
2. **Hex load**: data_in=0xBEEF, dec_mode=0, blank_lz=0.
   - busy high exactly 1 cycle.
   - Slots 0..3 show SEG F=0001110, E=0000110, E=0000110, b=0000011.
3. **Decimal load**: data_in=1234, dec_mode=1.
   - busy high exactly 17 cycles.
   - Slots 0..3 show 4=0011001, 3=0110000, 2=0100100, 1=1111001.
   - The old value stays displayed during CONV.
4. **Overflow**: decimal load of 10000, then of 65535 (with blank_lz=1).
   - All four slots active with SEG=0111111.
   - Then decimal 9999 shows 9 in all four slots.
5. **Blanking**: hex 0x0007 with blank_lz=1 and dp_in=0001.
   - Slot 0: AN=1110, SEG=1111000, DP=0.
   - Slots 1–3: AN=1111.
   - Hex 0x0000 with blank_lz=1 shows a single 0 in slot 0.
6. **Collisions**:
   - data_valid pulsed at CONV cycle 5: ignored, the result is still that of the first load.
   - rst at CONV cycle 8: busy=0 next edge; display reads "0000".
